alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 26 ++
 rtl/alu_arbiter_if.sv | 32 +++
 rtl/alu_arbiter_rr_arbiter.sv | 27 ++
 rtl/alu_arbiter.sv | 119 +++++++++++
 tb/tb_alu_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: datapath widths, ALU opcodes and FSM states.
package alu_arbiter_pkg;

  localparam int unsigned BIT_OP   = 3;
  localparam int unsigned BIT_DATA = 16;

  // OP_IDLE tells the ALU to hold its registered output.
  typedef enum logic [BIT_OP-1:0] {
    OP_IDLE = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_MUL  = 3'd6,
    OP_DIV  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StCapture = 2'd2,
    StResp    = 2'd3
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU signals of the arbiter; slave is the arbiter side.
interface alu_arbiter_if #(
  parameter int unsigned N_REQ = 2
);
  import alu_arbiter_pkg::*;

  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ*BIT_OP-1:0]   req_op;
  logic [N_REQ*BIT_DATA-1:0] req_a;
  logic [N_REQ*BIT_DATA-1:0] req_b;
  logic [N_REQ-1:0]          resp_valid;
  logic [N_REQ-1:0]          resp_ready;
  logic [BIT_DATA-1:0]       resp_data;
  logic                      resp_err;
  logic [BIT_OP-1:0]         alu_op;
  logic [BIT_DATA-1:0]       alu_din0;
  logic [BIT_DATA-1:0]       alu_din1;
  logic [BIT_DATA-1:0]       alu_dout;
  logic                      busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready, alu_dout,
    output req_ready, resp_valid, resp_data, resp_err, alu_op, alu_din0, alu_din1, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready, alu_dout,
    input  req_ready, resp_valid, resp_data, resp_err, alu_op, alu_din0, alu_din1, busy
  );

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin selector: one-hot grant to the first request after the pointer index.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant
);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      w_idx = IDX_W'((int'(i_ptr) + k) % int'(N_REQ));
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered-output ALU among N_REQ requesters, one operation in flight at a time.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input logic          clock,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  state_e              r_state;
  state_e              w_state_next;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    r_last;
  logic [IDX_W-1:0]    w_grant_idx;
  logic [N_REQ-1:0]    w_grant;
  logic [BIT_OP-1:0]   r_op;
  logic [BIT_DATA-1:0] r_a;
  logic [BIT_DATA-1:0] r_b;
  logic [BIT_DATA-1:0] r_data;
  logic                r_err;
  logic [BIT_OP-1:0]   w_sel_op;
  logic [BIT_DATA-1:0] w_sel_a;
  logic [BIT_DATA-1:0] w_sel_b;
  logic                w_accept;
  logic                w_div0;
  logic                w_resp_done;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .i_req   (bus.req_valid),
    .i_ptr   (r_last),
    .o_grant (w_grant)
  );

  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (w_grant[i]) w_grant_idx = IDX_W'(i);
    end
  end

  assign w_sel_op    = bus.req_op[w_grant_idx*BIT_OP +: BIT_OP];
  assign w_sel_a     = bus.req_a[w_grant_idx*BIT_DATA +: BIT_DATA];
  assign w_sel_b     = bus.req_b[w_grant_idx*BIT_DATA +: BIT_DATA];
  assign w_accept    = (r_state == StIdle) && !reset && (|bus.req_valid);
  assign w_div0      = (w_sel_op == OP_DIV) && (w_sel_b == '0);
  assign w_resp_done = (r_state == StResp) && bus.resp_ready[r_idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:    if (w_accept) w_state_next = w_div0 ? StResp : StIssue;
      StIssue:   w_state_next = StCapture;
      StCapture: w_state_next = StResp;
      StResp:    if (w_resp_done) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // A divide by zero never reaches the ALU; the error result is loaded at accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx  <= '0;
      r_last <= IDX_W'(N_REQ - 1);
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= w_sel_op;
        r_a   <= w_sel_a;
        r_b   <= w_sel_b;
        r_idx <= w_grant_idx;
        if (w_div0) begin
          r_data <= '1;
          r_err  <= 1'b1;
        end
      end
      if (r_state == StCapture) begin
        r_data <= bus.alu_dout;
        r_err  <= 1'b0;
      end
      if (w_resp_done) r_last <= r_idx;
    end
  end

  always_comb begin
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    bus.alu_op     = OP_IDLE;
    bus.alu_din0   = '0;
    bus.alu_din1   = '0;
    if (r_state == StIdle && !reset) bus.req_ready = w_grant;
    if (r_state == StResp) bus.resp_valid[r_idx] = 1'b1;
    if (r_state == StIssue) begin
      bus.alu_op   = r_op;
      bus.alu_din0 = r_a;
      bus.alu_din1 = r_b;
    end
  end

  assign bus.resp_data = r_data;
  assign bus.resp_err  = r_err;
  assign bus.busy      = (r_state != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two-requester and three-requester instances, each with an ALU stub.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   ptr2 = 1;

  always #5 clock = ~clock;

  alu_arbiter_if #(.N_REQ(2)) bus2 ();
  alu_arbiter_if #(.N_REQ(3)) bus3 ();

  alu_arbiter #(.N_REQ(2)) dut2 (.clock(clock), .reset(reset), .bus(bus2));
  alu_arbiter #(.N_REQ(3)) dut3 (.clock(clock), .reset(reset), .bus(bus3));

  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_MUL:  return a * b;
      OP_DIV:  return (b == 16'd0) ? 16'hFFFF : a / b;
      default: return 16'd0;
    endcase
  endfunction

  // ALU stubs: registered result, hold on OP_IDLE.
  always @(posedge clock or posedge reset) begin
    if (reset) bus2.alu_dout <= 16'd0;
    else if (bus2.alu_op != OP_IDLE)
      bus2.alu_dout <= alu_f(bus2.alu_op, bus2.alu_din0, bus2.alu_din1);
  end

  always @(posedge clock or posedge reset) begin
    if (reset) bus3.alu_dout <= 16'd0;
    else if (bus3.alu_op != OP_IDLE)
      bus3.alu_dout <= alu_f(bus3.alu_op, bus3.alu_din0, bus3.alu_din1);
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req2(input int i, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b);
    bus2.req_op[i*3 +: 3]   = op;
    bus2.req_a[i*16 +: 16]  = a;
    bus2.req_b[i*16 +: 16]  = b;
  endtask

  task automatic rnd_op(output logic [2:0] op, output logic [15:0] a, output logic [15:0] b);
    op = 3'($urandom_range(1, 7));
    a  = 16'($urandom);
    b  = (op == OP_DIV && $urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom);
  endtask

  task automatic test_reset();
    bus2.req_valid = 2'b11;
    set_req2(0, OP_ADD, 16'd1, 16'd2);
    set_req2(1, OP_ADD, 16'd3, 16'd4);
    repeat (2) cyc();
    #1;
    checks++; if (bus2.req_ready !== 2'b00) begin failures++;
      $display("FAIL reset_req_ready got=%b exp=00", bus2.req_ready); end
    checks++; if (bus2.resp_valid !== 2'b00) begin failures++;
      $display("FAIL reset_resp_valid got=%b exp=00", bus2.resp_valid); end
    checks++; if (bus2.resp_data !== 16'd0 || bus2.resp_err !== 1'b0) begin failures++;
      $display("FAIL reset_resp got=%h/%b exp=0000/0", bus2.resp_data, bus2.resp_err); end
    checks++; if (bus2.busy !== 1'b0) begin failures++;
      $display("FAIL reset_busy got=%b exp=0", bus2.busy); end
    checks++; if (bus2.alu_op !== OP_IDLE || bus2.alu_din0 !== 16'd0 || bus2.alu_din1 !== 16'd0)
      begin failures++; $display("FAIL reset_alu got=%h/%h/%h exp=0/0/0",
                                 bus2.alu_op, bus2.alu_din0, bus2.alu_din1); end
    bus2.req_valid = 2'b00;
    reset = 1'b0;
    ptr2 = 1;
    cyc();
  endtask

  task automatic test_single();
    set_req2(0, OP_ADD, 16'd5, 16'd3);
    bus2.req_valid  = 2'b01;
    bus2.resp_ready = 2'b01;
    #1;
    checks++; if (bus2.req_ready !== 2'b01) begin failures++;
      $display("FAIL single_ready got=%b exp=01", bus2.req_ready); end
    cyc();
    bus2.req_valid = 2'b00;
    #1;
    checks++; if (bus2.req_ready !== 2'b00) begin failures++;
      $display("FAIL single_ready_drop got=%b exp=00", bus2.req_ready); end
    checks++; if (bus2.alu_op !== OP_ADD || bus2.alu_din0 !== 16'd5 || bus2.alu_din1 !== 16'd3)
      begin failures++; $display("FAIL single_issue got=%h/%h/%h exp=1/5/3",
                                 bus2.alu_op, bus2.alu_din0, bus2.alu_din1); end
    cyc();
    checks++; if (bus2.resp_valid !== 2'b00 || bus2.alu_op !== OP_IDLE) begin failures++;
      $display("FAIL single_capture got=%b/%h exp=00/0", bus2.resp_valid, bus2.alu_op); end
    cyc();
    checks++; if (bus2.resp_valid !== 2'b01 || bus2.resp_data !== 16'd8 || bus2.resp_err !== 1'b0)
      begin failures++; $display("FAIL single_resp got=%b/%0d/%b exp=01/8/0",
                                 bus2.resp_valid, bus2.resp_data, bus2.resp_err); end
    cyc();
    checks++; if (bus2.busy !== 1'b0) begin failures++;
      $display("FAIL single_done_busy got=%b exp=0", bus2.busy); end
    ptr2 = 0;
  endtask

  task automatic test_contention();
    logic [2:0]  op [2];
    logic [15:0] a [2];
    logic [15:0] b [2];
    logic [15:0] ed;
    logic        ee;
    int          g;
    int          lat;
    for (int i = 0; i < 2; i++) begin
      rnd_op(op[i], a[i], b[i]);
      set_req2(i, op[i], a[i], b[i]);
    end
    bus2.req_valid  = 2'b11;
    bus2.resp_ready = 2'b11;
    for (int n = 0; n < 6; n++) begin
      #1;
      g = (ptr2 + 1) % 2;
      checks++; if (bus2.req_ready !== 2'(1 << g)) begin failures++;
        $display("FAIL contention_grant n=%0d got=%b exp=%b", n, bus2.req_ready, 2'(1 << g)); end
      ee = (op[g] == OP_DIV) && (b[g] == 16'd0);
      ed = ee ? 16'hFFFF : alu_f(op[g], a[g], b[g]);
      cyc();
      rnd_op(op[g], a[g], b[g]);
      set_req2(g, op[g], a[g], b[g]);
      #1;
      lat = 0;
      while (bus2.resp_valid == 2'b00 && lat < 6) begin
        cyc();
        lat++;
      end
      checks++; if (bus2.resp_valid !== 2'(1 << g) || lat != (ee ? 0 : 2)) begin failures++;
        $display("FAIL contention_route n=%0d got=%b lat=%0d exp=%b lat=%0d",
                 n, bus2.resp_valid, lat, 2'(1 << g), ee ? 0 : 2); end
      checks++; if (bus2.resp_data !== ed || bus2.resp_err !== ee) begin failures++;
        $display("FAIL contention_data n=%0d got=%h/%b exp=%h/%b",
                 n, bus2.resp_data, bus2.resp_err, ed, ee); end
      cyc();
      ptr2 = g;
    end
    bus2.req_valid = 2'b00;
    cyc();
  endtask

  task automatic test_backpressure();
    int t;
    set_req2(0, OP_XOR, 16'h1234, 16'h00FF);
    set_req2(1, OP_SUB, 16'd100, 16'd1);
    bus2.req_valid  = 2'b01;
    bus2.resp_ready = 2'b10;
    #1;
    checks++; if (bus2.req_ready !== 2'b01) begin failures++;
      $display("FAIL bp_grant got=%b exp=01", bus2.req_ready); end
    cyc();
    bus2.req_valid = 2'b10;
    cyc();
    cyc();
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (bus2.resp_valid !== 2'b01 || bus2.resp_data !== 16'h12CB) begin failures++;
        $display("FAIL bp_hold k=%0d got=%b/%h exp=01/12cb", k, bus2.resp_valid, bus2.resp_data);
      end
      checks++; if (bus2.req_ready !== 2'b00 || bus2.busy !== 1'b1) begin failures++;
        $display("FAIL bp_busy k=%0d got=%b/%b exp=00/1", k, bus2.req_ready, bus2.busy); end
      cyc();
    end
    bus2.resp_ready = 2'b01;
    cyc();
    ptr2 = 0;
    #1;
    checks++; if (bus2.req_ready !== 2'b10) begin failures++;
      $display("FAIL bp_waiter_grant got=%b exp=10", bus2.req_ready); end
    cyc();
    bus2.req_valid  = 2'b00;
    bus2.resp_ready = 2'b10;
    t = 0;
    while (bus2.resp_valid == 2'b00 && t < 6) begin
      cyc();
      t++;
    end
    checks++; if (bus2.resp_valid !== 2'b10 || bus2.resp_data !== 16'd99) begin failures++;
      $display("FAIL bp_waiter_resp got=%b/%0d exp=10/99", bus2.resp_valid, bus2.resp_data); end
    cyc();
    ptr2 = 1;
  endtask

  task automatic test_div0();
    set_req2(0, OP_DIV, 16'd9, 16'd0);
    bus2.req_valid  = 2'b01;
    bus2.resp_ready = 2'b00;
    #1;
    checks++; if (bus2.req_ready !== 2'b01) begin failures++;
      $display("FAIL div0_grant got=%b exp=01", bus2.req_ready); end
    cyc();
    bus2.req_valid = 2'b00;
    #1;
    checks++; if (bus2.resp_valid !== 2'b01 || bus2.resp_data !== 16'hFFFF || bus2.resp_err !== 1'b1)
      begin failures++; $display("FAIL div0_resp got=%b/%h/%b exp=01/ffff/1",
                                 bus2.resp_valid, bus2.resp_data, bus2.resp_err); end
    checks++; if (bus2.alu_op !== OP_IDLE) begin failures++;
      $display("FAIL div0_alu_op got=%h exp=0", bus2.alu_op); end
    bus2.resp_ready = 2'b01;
    cyc();
    checks++; if (bus2.busy !== 1'b0 || bus2.alu_op !== OP_IDLE) begin failures++;
      $display("FAIL div0_done got=%b/%h exp=0/0", bus2.busy, bus2.alu_op); end
    ptr2 = 0;
  endtask

  task automatic test_random();
    bit          pend [2];
    bit          infl;
    int          own, age, lat, g;
    logic [2:0]  op [2];
    logic [15:0] a [2];
    logic [15:0] b [2];
    logic [15:0] ed;
    logic        ee;
    logic [1:0]  erdy, evld;
    infl = 1'b0; own = 0; age = 0; lat = 0; ed = '0; ee = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int c = 0; c < 330; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && c < 300 && $urandom_range(0, 1) == 1) begin
          rnd_op(op[i], a[i], b[i]);
          set_req2(i, op[i], a[i], b[i]);
          pend[i] = 1'b1;
        end
      end
      bus2.req_valid  = {pend[1], pend[0]};
      bus2.resp_ready = (c < 300) ? 2'($urandom) : 2'b11;
      #1;
      g = -1;
      if (!infl) begin
        for (int k = 1; k <= 2; k++) if (g < 0 && pend[(ptr2 + k) % 2]) g = (ptr2 + k) % 2;
      end
      erdy = (g >= 0) ? 2'(1 << g) : 2'b00;
      evld = (infl && age >= lat) ? 2'(1 << own) : 2'b00;
      checks++; if (bus2.req_ready !== erdy) begin failures++;
        $display("FAIL rand_ready c=%0d got=%b exp=%b", c, bus2.req_ready, erdy); end
      checks++; if (bus2.resp_valid !== evld) begin failures++;
        $display("FAIL rand_resp_valid c=%0d got=%b exp=%b", c, bus2.resp_valid, evld); end
      checks++; if (bus2.busy !== infl) begin failures++;
        $display("FAIL rand_busy c=%0d got=%b exp=%b", c, bus2.busy, infl); end
      if (evld != 2'b00) begin
        checks++; if (bus2.resp_data !== ed || bus2.resp_err !== ee) begin failures++;
          $display("FAIL rand_data c=%0d got=%h/%b exp=%h/%b",
                   c, bus2.resp_data, bus2.resp_err, ed, ee); end
      end
      if (g >= 0) begin
        infl = 1'b1; own = g; age = 0;
        ee   = (op[g] == OP_DIV) && (b[g] == 16'd0);
        ed   = ee ? 16'hFFFF : alu_f(op[g], a[g], b[g]);
        lat  = ee ? 0 : 2;
        pend[g] = 1'b0;
      end else if (infl) begin
        if (age >= lat && bus2.resp_ready[own]) begin
          infl = 1'b0;
          ptr2 = own;
        end else begin
          age++;
        end
      end
      cyc();
    end
    bus2.req_valid = 2'b00;
  endtask

  task automatic test_reset_mid();
    int t;
    set_req2(1, OP_ADD, 16'd7, 16'd7);
    bus2.req_valid  = 2'b10;
    bus2.resp_ready = 2'b11;
    #1;
    checks++; if (bus2.req_ready !== 2'b10) begin failures++;
      $display("FAIL rmid_grant got=%b exp=10", bus2.req_ready); end
    cyc();
    bus2.req_valid = 2'b00;
    cyc();
    reset = 1'b1;
    #1;
    checks++; if (bus2.busy !== 1'b0 || bus2.resp_valid !== 2'b00 || bus2.req_ready !== 2'b00)
      begin failures++; $display("FAIL rmid_ctrl got=%b/%b/%b exp=0/00/00",
                                 bus2.busy, bus2.resp_valid, bus2.req_ready); end
    checks++; if (bus2.resp_data !== 16'd0 || bus2.resp_err !== 1'b0 || bus2.alu_op !== OP_IDLE ||
                  bus2.alu_din0 !== 16'd0 || bus2.alu_din1 !== 16'd0) begin failures++;
      $display("FAIL rmid_data got=%h/%b/%h exp=0000/0/0",
               bus2.resp_data, bus2.resp_err, bus2.alu_op); end
    cyc();
    reset = 1'b0;
    ptr2 = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++; if (bus2.resp_valid !== 2'b00 || bus2.busy !== 1'b0) begin failures++;
        $display("FAIL rmid_quiet k=%0d got=%b/%b exp=00/0", k, bus2.resp_valid, bus2.busy); end
    end
    set_req2(0, OP_SUB, 16'd10, 16'd4);
    bus2.req_valid = 2'b11;
    #1;
    checks++; if (bus2.req_ready !== 2'b01) begin failures++;
      $display("FAIL rmid_first_grant got=%b exp=01", bus2.req_ready); end
    cyc();
    bus2.req_valid = 2'b00;
    t = 0;
    while (bus2.resp_valid == 2'b00 && t < 6) begin
      cyc();
      t++;
    end
    checks++; if (bus2.resp_valid !== 2'b01 || bus2.resp_data !== 16'd6) begin failures++;
      $display("FAIL rmid_resp got=%b/%0d exp=01/6", bus2.resp_valid, bus2.resp_data); end
    cyc();
    ptr2 = 0;
  endtask

  task automatic test_wrap();
    int          exp_order [4] = '{0, 1, 2, 0};
    logic [15:0] a [3];
    logic [15:0] b [3];
    int          g, t;
    for (int i = 0; i < 3; i++) begin
      a[i] = 16'($urandom);
      b[i] = 16'($urandom);
      bus3.req_op[i*3 +: 3]  = OP_ADD;
      bus3.req_a[i*16 +: 16] = a[i];
      bus3.req_b[i*16 +: 16] = b[i];
    end
    bus3.req_valid  = 3'b111;
    bus3.resp_ready = 3'b111;
    for (int n = 0; n < 4; n++) begin
      #1;
      g = exp_order[n];
      checks++; if (bus3.req_ready !== 3'(1 << g)) begin failures++;
        $display("FAIL wrap_grant n=%0d got=%b exp=%b", n, bus3.req_ready, 3'(1 << g)); end
      cyc();
      t = 0;
      while (bus3.resp_valid == 3'b000 && t < 6) begin
        cyc();
        t++;
      end
      checks++; if (bus3.resp_valid !== 3'(1 << g) || bus3.resp_data !== 16'(a[g] + b[g]))
        begin failures++; $display("FAIL wrap_resp n=%0d got=%b/%h exp=%b/%h", n,
                                   bus3.resp_valid, bus3.resp_data, 3'(1 << g), 16'(a[g] + b[g]));
      end
      cyc();
    end
    bus3.req_valid = 3'b000;
    cyc();
  endtask

  initial begin
    bus2.req_valid = '0; bus2.req_op = '0; bus2.req_a = '0; bus2.req_b = '0;
    bus2.resp_ready = '0;
    bus3.req_valid = '0; bus3.req_op = '0; bus3.req_a = '0; bus3.req_b = '0;
    bus3.resp_ready = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_div0();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
